flit_injector: RTL and testbench
================================

Name: flit_injector

Overview:
- Sits directly downstream of the traffic generator, between it and the router local input port.
- Pulls flits from the generator by issuing Dequeue ops and captures the generator's registered flit/VC output.
- Forwards each flit onto the local link only when the target VC holds a downstream credit.
- Tracks per-VC credits returned by the router and reports completion once the generator signals done and no flit is pending.

Parameters:
NUM_VC, 4, number of virtual channels at the router local port
VC_W, 2, VC index width, clog2(NUM_VC)
FLIT_W, 16, flit width, matches generator flit field
BUF_DEPTH, 4, router input buffer depth per VC = initial credits
CRED_W, 3, credit counter width, holds 0..BUF_DEPTH
HEAD_BIT, 14, flit bit carrying head flag
TAIL_BIT, 15, flit bit carrying tail flag

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; host has already Init/Fill'd the generator
gen_op  out  3  op to generator: NOP=0, Dequeue=7 only
gen_flit  in  FLIT_W  generator output flit
gen_vc  in  VC_W  generator output VC
gen_done  in  1  generator done (all packets sent)
link_valid  out  1  flit valid on local link, one cycle per flit
link_flit  out  FLIT_W  registered flit to router
link_vc  out  VC_W  registered VC to router
credit_valid  in  1  router returns one credit
credit_vc  in  VC_W  VC of returned credit
busy  out  1  high from start accepted until DONE
done  out  1  high in DONE, held until next start or rst
credit_err  out  1  sticky: credit returned to a full counter

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE; gen_op=NOP; link_valid=0; link_flit=0; link_vc=0; busy=0; done=0; credit_err=0.
  - Every credit counter=BUF_DEPTH; holding register empty.
  - Reset mid-run abandons any held flit without sending it.
- All outputs are registered.
- FSM:
  - IDLE: on start -> REQ; busy=1, done=0.
  - REQ: if gen_done=1 -> DONE. Else drive gen_op=Dequeue for exactly one cycle -> WAIT.
  - WAIT: gen_op=NOP. The generator updates its output on the Dequeue edge; this state samples gen_flit/gen_vc into the holding register at the end of the cycle -> SEND.
  - SEND: if credit[held_vc]>0: next edge link_valid=1 with held flit/VC, credit[held_vc]-1, holding cleared -> REQ. Else stall in SEND with link_valid=0.
  - DONE: done=1, busy=0; start -> REQ with done cleared.
- start is ignored outside IDLE/DONE.
- Latency: minimum 3 cycles per flit (REQ, WAIT, SEND); link_valid never high on consecutive cycles.
- Credits:
  - credit_valid increments credit[credit_vc] in any state.
  - Same-cycle send and return on the same VC leaves the count unchanged.
  - Return when the count is already BUF_DEPTH: count saturates at BUF_DEPTH and credit_err sets; cleared only by rst.
  - Counter width arithmetic is unsigned; no wrap permitted.
- gen_done is sampled only in REQ; a flit already held is always sent before DONE.
- credit_vc >= NUM_VC is ignored.

Optional Feature:
- Macro INJ_STATS_EN.
- Defined: adds outputs stat_flits[15:0], stat_pkts[15:0] (count of sent flits with TAIL_BIT=1) and stat_stall[15:0] (SEND cycles with zero credit).
  - All three saturate at 16'hFFFF.
  - Cleared on rst and on start.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared parameters file holds:
  - the op codes (NOP, Init=5, Fill=6, Dequeue=7);
  - the flit field positions (head, tail, destination);
  - VC width and default BUF_DEPTH.
- The FSM state encoding lives locally.
- One sub-module, credit_counter_bank: NUM_VC saturating up/down counters with a sticky overflow flag. The FSM uses its per-VC nonzero vector.

Test Plan:
- Reset then start with gen_done=0, generator supplying 3 flits on VC1 with BUF_DEPTH=4, no credit return -> link_valid pulses at cycles 3, 6, 9 after start; credit[1]=1.
- 5 flits on VC0 with no credits returned -> 4 sent, 5th stalls in SEND; credit_valid on VC0 -> 5th flit sent on the following edge.
- Same-cycle link send and credit_valid on VC2 -> credit[2] unchanged (4 stays 4 after first send plus return).
- Credit returned on VC3 while credit[3]=4 -> credit[3]=4, credit_err=1 and stays 1 until rst.
- gen_done asserted while a flit is held -> flit is still sent, then done=1, busy=0; a new start re-enters REQ.
- rst asserted in SEND with 0 credits -> next cycle all outputs are at reset values, credits=4, no link_valid.

Source files
------------

// File: rtl/flit_injector_pkg.sv
// Shared definitions for the flit injector: generator op codes,
// flit field positions, VC width and default per-VC credit depth.
package flit_injector_pkg;

    localparam int NUM_VC    = 4;
    localparam int VC_W      = 2;
    localparam int FLIT_W    = 16;
    localparam int BUF_DEPTH = 4;
    localparam int CRED_W    = 3;

    localparam int HEAD_BIT  = 14;
    localparam int TAIL_BIT  = 15;
    localparam int DEST_LSB  = 0;
    localparam int DEST_W    = 4;

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);
    localparam logic [VC_W:0]     VC_LIM   = (VC_W+1)'(NUM_VC);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_INIT = 3'd5,
        OP_FILL = 3'd6,
        OP_DEQ  = 3'd7
    } gen_op_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/flit_injector_credit_counter_bank.sv
// Per-VC saturating credit counters with a sticky overflow flag.
// A return and a send on the same VC in one cycle cancel out.
module credit_counter_bank
    import flit_injector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [VC_W-1:0]   inc_vc,
    input  logic              dec,
    input  logic [VC_W-1:0]   dec_vc,
    output logic [NUM_VC-1:0] nonzero,
    output logic              overflow
);

    logic [CRED_W-1:0] cnt [NUM_VC];
    logic [NUM_VC-1:0] up;
    logic [NUM_VC-1:0] dn;
    logic [NUM_VC-1:0] full;
    logic              inc_ok;

    // Out-of-range VC indices never touch a counter.
    assign inc_ok = inc && ({1'b0, inc_vc} < VC_LIM);

    // Decode per-VC up/down requests and counter status.
    always_comb begin
        up      = '0;
        dn      = '0;
        full    = '0;
        nonzero = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            up[i]      = inc_ok && (inc_vc == VC_W'(i));
            dn[i]      = dec && (dec_vc == VC_W'(i));
            full[i]    = (cnt[i] == CRED_MAX);
            nonzero[i] = (cnt[i] != '0);
        end
    end

    // Counters saturate at both ends; a return into a full counter is sticky-flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VC; i++) begin
                cnt[i] <= CRED_MAX;
            end
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                if (up[i] && !dn[i] && !full[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (dn[i] && !up[i] && nonzero[i]) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
            if (|(up & ~dn & full)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/flit_injector.sv
// Pulls flits from the traffic generator and injects them on the local
// router link under per-VC credit control. INJ_STATS_EN adds stat counters.
module flit_injector
    import flit_injector_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [2:0]        gen_op,
    input  logic [FLIT_W-1:0] gen_flit,
    input  logic [VC_W-1:0]   gen_vc,
    input  logic              gen_done,
    output logic              link_valid,
    output logic [FLIT_W-1:0] link_flit,
    output logic [VC_W-1:0]   link_vc,
    input  logic              credit_valid,
    input  logic [VC_W-1:0]   credit_vc,
    output logic              busy,
    output logic              done,
    output logic              credit_err
`ifdef INJ_STATS_EN
    ,
    output logic [15:0]       stat_flits,
    output logic [15:0]       stat_pkts,
    output logic [15:0]       stat_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state;
    logic [FLIT_W-1:0] held_flit;
    logic [VC_W-1:0]   held_vc;
    logic [NUM_VC-1:0] vc_ok;
    logic              send;

    assign send = (state == S_SEND) && vc_ok[held_vc];

    credit_counter_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .inc      (credit_valid),
        .inc_vc   (credit_vc),
        .dec      (send),
        .dec_vc   (held_vc),
        .nonzero  (vc_ok),
        .overflow (credit_err)
    );

    // Injection FSM: one Dequeue per flit, capture, then send when credited.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gen_op     <= OP_NOP;
            link_valid <= 1'b0;
            link_flit  <= '0;
            link_vc    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            held_flit  <= '0;
            held_vc    <= '0;
        end else begin
            gen_op     <= OP_NOP;
            link_valid <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_REQ;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (gen_done) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        gen_op <= OP_DEQ;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    held_flit <= gen_flit;
                    held_vc   <= gen_vc;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (send) begin
                        link_valid <= 1'b1;
                        link_flit  <= held_flit;
                        link_vc    <= held_vc;
                        held_flit  <= '0;
                        held_vc    <= '0;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef INJ_STATS_EN
    logic start_ok;
    logic stall;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign stall    = (state == S_SEND) && !vc_ok[held_vc];

    // Saturating activity counters, restarted with each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            stat_flits <= '0;
            stat_pkts  <= '0;
            stat_stall <= '0;
        end else begin
            if (send) begin
                stat_flits <= sat_inc16(stat_flits);
                if (held_flit[TAIL_BIT]) begin
                    stat_pkts <= sat_inc16(stat_pkts);
                end
            end
            if (stall) begin
                stat_stall <= sat_inc16(stat_stall);
            end
        end
    end
`endif

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector with a generator model and a
// scoreboard of expected link flits.
module tb_flit_injector;
    import flit_injector_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              credit_valid = 1'b0;
    logic [VC_W-1:0]   credit_vc = '0;
    logic [2:0]        gen_op;
    logic [FLIT_W-1:0] gen_flit;
    logic [VC_W-1:0]   gen_vc;
    logic              gen_done;
    logic              link_valid;
    logic [FLIT_W-1:0] link_flit;
    logic [VC_W-1:0]   link_vc;
    logic              busy;
    logic              done;
    logic              credit_err;
`ifdef INJ_STATS_EN
    logic [15:0]       stat_flits;
    logic [15:0]       stat_pkts;
    logic [15:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    flit_injector dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .gen_op       (gen_op),
        .gen_flit     (gen_flit),
        .gen_vc       (gen_vc),
        .gen_done     (gen_done),
        .link_valid   (link_valid),
        .link_flit    (link_flit),
        .link_vc      (link_vc),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .busy         (busy),
        .done         (done),
        .credit_err   (credit_err)
`ifdef INJ_STATS_EN
        ,
        .stat_flits   (stat_flits),
        .stat_pkts    (stat_pkts),
        .stat_stall   (stat_stall)
`endif
    );

    // Generator model: show-ahead list, advanced on each Dequeue edge.
    logic [FLIT_W-1:0] gflit [32];
    logic [VC_W-1:0]   gvcs  [32];
    int gidx = 0;
    int gcnt = 0;

    assign gen_flit = gflit[gidx[4:0]];
    assign gen_vc   = gvcs[gidx[4:0]];
    assign gen_done = (gidx >= gcnt);

    always @(posedge clk) begin
        if (gen_op == OP_DEQ && gidx < gcnt) gidx <= gidx + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int n_sent = 0;
    int c_start = 0;
    int lvq[$];
    logic [VC_W+FLIT_W-1:0] expq[$];
    logic prev_lv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every link beat must match the next expected flit.
    always @(negedge clk) begin
        logic [VC_W+FLIT_W-1:0] e;
        if (link_valid) begin
            lvq.push_back(cyc);
            n_sent++;
            check("lv_back_to_back", 32'(prev_lv), 32'd0);
            if (expq.size() == 0) begin
                check("unexpected_flit", 32'(link_flit), 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                check("link_vc", 32'(link_vc), 32'(e[VC_W+FLIT_W-1:FLIT_W]));
                check("link_flit", 32'(link_flit), 32'(e[FLIT_W-1:0]));
            end
        end
        prev_lv = link_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_flit(input logic [VC_W-1:0] vc,
                            input logic [FLIT_W-1:0] f);
        gflit[gcnt] = f;
        gvcs[gcnt]  = vc;
        gcnt++;
        expq.push_back({vc, f});
    endtask

    task automatic pulse_start();
        start   = 1'b1;
        c_start = cyc + 1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 100) begin
            tick(1);
            k++;
        end
        check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int base;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rst_gen_op", 32'(gen_op), 32'd0);
        check("rst_link_valid", 32'(link_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_credit_err", 32'(credit_err), 32'd0);

        // Three flits on VC1: beats at 3, 6, 9 cycles after start.
        add_flit(2'd1, 16'h4011);
        add_flit(2'd1, 16'h0012);
        add_flit(2'd1, 16'h8013);
        lvq.delete();
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_done", 32'(done), 32'd0);
        wait_done();
        check("t1_beats", 32'(lvq.size()), 32'd3);
        if (lvq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t1_latency", 32'(lvq[i] - c_start), 32'(3 * (i + 1)));
            end
        end
        check("t1_cred1", 32'(dut.u_bank.cnt[1]), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Five flits on VC0 with four credits: fifth stalls until a return.
        base = n_sent;
        for (int i = 0; i < 5; i++) add_flit(2'd0, 16'h0100 + 16'(i));
        pulse_start();
        tick(25);
        check("t2_sent4", 32'(n_sent - base), 32'd4);
        check("t2_cred0", 32'(dut.u_bank.cnt[0]), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        credit_valid = 1'b1;
        credit_vc    = 2'd0;
        tick(1);
        credit_valid = 1'b0;
        check("t2_no_send_yet", 32'(link_valid), 32'd0);
        check("t2_cred0_ret", 32'(dut.u_bank.cnt[0]), 32'd1);
        tick(1);
        check("t2_fifth_sent", 32'(link_valid), 32'd1);
        wait_done();
        check("t2_sent5", 32'(n_sent - base), 32'd5);

        // Send and return on VC2 in the same cycle.
        add_flit(2'd2, 16'hC020);
        pulse_start();
        tick(2);
        credit_valid = 1'b1;
        credit_vc    = 2'd2;
        tick(1);
        credit_valid = 1'b0;
        check("t3_send", 32'(link_valid), 32'd1);
        check("t3_cred2", 32'(dut.u_bank.cnt[2]), 32'd4);
        check("t3_no_err", 32'(credit_err), 32'd0);
        wait_done();

        // Return into a full counter on VC3.
        credit_valid = 1'b1;
        credit_vc    = 2'd3;
        tick(1);
        credit_valid = 1'b0;
        check("t4_cred3", 32'(dut.u_bank.cnt[3]), 32'd4);
        check("t4_err", 32'(credit_err), 32'd1);
        tick(3);
        check("t4_err_sticky", 32'(credit_err), 32'd1);

        // gen_done rises while the last flit is held.
        add_flit(2'd3, 16'h8033);
        pulse_start();
        tick(2);
        check("t5_held_busy", 32'(busy), 32'd1);
        check("t5_held_done", 32'(done), 32'd0);
        tick(1);
        check("t5_sent", 32'(link_valid), 32'd1);
        tick(1);
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_err_sticky", 32'(credit_err), 32'd1);
        pulse_start();
        check("t5_restart_busy", 32'(busy), 32'd1);
        check("t5_restart_done", 32'(done), 32'd0);
        tick(1);
        check("t5_redone", 32'(done), 32'd1);

        // Reset while stalled in SEND with zero credit.
        add_flit(2'd0, 16'h0044);
        pulse_start();
        tick(6);
        check("t6_stalled", 32'(link_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_cred0", 32'(dut.u_bank.cnt[0]), 32'd0);
        rst = 1'b1;
        tick(1);
        check("t6_gen_op", 32'(gen_op), 32'd0);
        check("t6_link_valid", 32'(link_valid), 32'd0);
        check("t6_link_flit", 32'(link_flit), 32'd0);
        check("t6_link_vc", 32'(link_vc), 32'd0);
        check("t6_busy_rst", 32'(busy), 32'd0);
        check("t6_done_rst", 32'(done), 32'd0);
        check("t6_err_rst", 32'(credit_err), 32'd0);
        for (int i = 0; i < NUM_VC; i++) begin
            check("t6_cred", 32'(dut.u_bank.cnt[i]), 32'd4);
        end
`ifdef INJ_STATS_EN
        check("t6_stat_flits", 32'(stat_flits), 32'd0);
`endif
        rst = 1'b0;
        if (expq.size() > 0) void'(expq.pop_front());
        tick(3);
        check("t6_no_send", 32'(link_valid), 32'd0);
        check("scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
